// File: rtl/orv64_napot_encode.sv
// Encodes an inclusive physical region [base, bounds] into a PMP NAPOT pmpaddr value.
// Bit-serial scan from bit 0 upward, behind valid/ready request and response handshakes.
module orv64_napot_encode #(
  parameter int PADDR_W = 56,
  parameter int SZ_W    = $clog2(PADDR_W + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [PADDR_W-1:0] req_base,
  input  logic [PADDR_W-1:0] req_bounds,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [PADDR_W-3:0] resp_pmpaddr,
  output logic [SZ_W-1:0]    resp_size_log2,
  output logic               resp_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [PADDR_W-1:0] base_q, base_d;
  logic [PADDR_W-1:0] bounds_q, bounds_d;
  logic [SZ_W-1:0]    idx_q, idx_d;
  logic [PADDR_W-3:0] pmpaddr_d;
  logic [SZ_W-1:0]    size_d;
  logic               err_d;

  logic               bit_pass;
  logic               last_bit;
  logic               upper_diff;
  logic [PADDR_W-3:0] low_ones;

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);

  // Bits below the stop index must be (0,1); everything from the stop index up must match.
  assign bit_pass   = ~base_q[idx_q] & bounds_q[idx_q];
  assign last_bit   = (idx_q == SZ_W'(PADDR_W - 1));
  assign upper_diff = (((base_q ^ bounds_q) >> idx_q) != '0);
  // ((1 << (n-1)) - 1) >> 2, formed directly in pmpaddr bit positions
  assign low_ones   = ~({(PADDR_W-2){1'b1}} << (idx_q - SZ_W'(3)));

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    bounds_d  = bounds_q;
    idx_d     = idx_q;
    pmpaddr_d = resp_pmpaddr;
    size_d    = resp_size_log2;
    err_d     = resp_err;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          base_d   = req_base;
          bounds_d = req_bounds;
          idx_d    = '0;
          state_d  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (bit_pass && !last_bit) begin
          idx_d = idx_q + SZ_W'(1);
        end else if (bit_pass) begin
          pmpaddr_d = '1;
          size_d    = SZ_W'(PADDR_W);
          err_d     = 1'b0;
          state_d   = ST_RESP;
        end else begin
          if (idx_q < SZ_W'(3) || upper_diff) begin
            pmpaddr_d = '0;
            size_d    = '0;
            err_d     = 1'b1;
          end else begin
            pmpaddr_d = base_q[PADDR_W-1:2] | low_ones;
            size_d    = idx_q;
            err_d     = 1'b0;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      base_q         <= '0;
      bounds_q       <= '0;
      idx_q          <= '0;
      resp_pmpaddr   <= '0;
      resp_size_log2 <= '0;
      resp_err       <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      bounds_q       <= bounds_d;
      idx_q          <= idx_d;
      resp_pmpaddr   <= pmpaddr_d;
      resp_size_log2 <= size_d;
      resp_err       <= err_d;
    end
  end

endmodule

// File: tb/tb_orv64_napot_encode.sv
// Directed and randomised checks of the NAPOT encoder, with an independent NAPOT decoder model.
module tb_orv64_napot_encode;

  localparam int PADDR_W = 56;
  localparam int SZ_W    = $clog2(PADDR_W + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [PADDR_W-1:0] req_base = '0;
  logic [PADDR_W-1:0] req_bounds = '0;
  logic               resp_valid;
  logic               resp_ready = 1'b0;
  logic [PADDR_W-3:0] resp_pmpaddr;
  logic [SZ_W-1:0]    resp_size_log2;
  logic               resp_err;

  int n_checks = 0;
  int n_fail   = 0;

  orv64_napot_encode #(.PADDR_W(PADDR_W), .SZ_W(SZ_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_base      (req_base),
    .req_bounds    (req_bounds),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_pmpaddr  (resp_pmpaddr),
    .resp_size_log2(resp_size_log2),
    .resp_err      (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Leaves the bench at the falling edge right after the request handshake edge.
  task automatic start_req(input logic [PADDR_W-1:0] b, input logic [PADDR_W-1:0] bd);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_wait", {63'd0, req_ready}, 64'd1);
    req_valid  = 1'b1;
    req_base   = b;
    req_bounds = bd;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  // Latency counts rising edges from the handshake edge through the edge raising resp_valid.
  task automatic wait_resp(input int start, output int lat);
    lat = start;
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) check("resp_timeout", 64'd0, 64'd1);
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic run_directed(input string tag, input logic [PADDR_W-1:0] b,
                              input logic [PADDR_W-1:0] bd, input logic [63:0] exp_pmp,
                              input int exp_sz, input logic exp_err, input int exp_lat);
    int lat;
    start_req(b, bd);
    wait_resp(1, lat);
    check({tag, "_pmpaddr"}, 64'(resp_pmpaddr), exp_pmp);
    check({tag, "_size"}, 64'(resp_size_log2), 64'(exp_sz));
    check({tag, "_err"}, 64'(resp_err), 64'(exp_err));
    if (exp_lat > 0) check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    finish_resp();
  endtask

  function automatic logic [PADDR_W-1:0] dec_mask(input logic [PADDR_W-3:0] p);
    int unsigned t;
    logic [63:0] m;
    t = 0;
    for (int unsigned i = 0; i < PADDR_W - 2; i++) begin
      if (p[i] && t == i) t = i + 1;
    end
    m = (64'd1 << (t + 3)) - 64'd1;
    return m[PADDR_W-1:0];
  endfunction

  task automatic run_model(input string tag, input logic [PADDR_W-1:0] b,
                           input logic [PADDR_W-1:0] bd);
    logic [63:0] s;
    logic [PADDR_W-1:0] m, db, dbd;
    logic napot;
    int n, lat;
    s     = {8'd0, bd} - {8'd0, b} + 64'd1;
    napot = (s >= 64'd8) && ((s & (s - 64'd1)) == 64'd0) && (({8'd0, b} & (s - 64'd1)) == 64'd0);
    n = 0;
    for (int unsigned i = 0; i < 64; i++) if (s == (64'd1 << i)) n = int'(i);
    start_req(b, bd);
    wait_resp(1, lat);
    check({tag, "_err"}, 64'(resp_err), napot ? 64'd0 : 64'd1);
    if (napot) begin
      m   = dec_mask(resp_pmpaddr);
      db  = {resp_pmpaddr, 2'b00} & ~m;
      dbd = db | m;
      check({tag, "_size"}, 64'(resp_size_log2), 64'(n));
      check({tag, "_dec_base"}, 64'(db), 64'(b));
      check({tag, "_dec_bounds"}, 64'(dbd), 64'(bd));
      check({tag, "_latency"}, 64'(lat), (n == PADDR_W) ? 64'(PADDR_W + 1) : 64'(n + 2));
    end else begin
      check({tag, "_pmpaddr"}, 64'(resp_pmpaddr), 64'd0);
      check({tag, "_size"}, 64'(resp_size_log2), 64'd0);
    end
    finish_resp();
  endtask

  initial begin
    logic [PADDR_W-3:0] held;
    logic [63:0] r, m;
    logic seen;
    int lat, n;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_outputs", {7'd0, resp_pmpaddr, resp_size_log2, resp_err}, 64'd0);

    run_directed("nom4k", 56'h8000_0000, 56'h8000_0FFF, 64'h2000_01FF, 12, 1'b0, 14);
    run_directed("min8", 56'h10, 56'h17, 64'h4, 3, 1'b0, 5);
    run_directed("sz4", 56'h1000, 56'h1003, 64'h0, 0, 1'b1, 4);
    run_directed("misal", 56'h1004, 56'h100B, 64'h0, 0, 1'b1, 0);
    run_directed("nonpow", 56'h1000, 56'h2FFF, 64'h0, 0, 1'b1, 14);
    run_directed("full", 56'h0, {PADDR_W{1'b1}}, {10'd0, {(PADDR_W-2){1'b1}}}, 56, 1'b0, 57);

    // Backpressure: result must hold while resp_ready stays low.
    start_req(56'h10, 56'h17);
    wait_resp(1, lat);
    held = resp_pmpaddr;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_pmpaddr", 64'(resp_pmpaddr), 64'(held));
      check("bp_valid_ready", {62'd0, resp_valid, req_ready}, 64'd2);
    end
    check("bp_value", 64'(resp_pmpaddr), 64'h4);
    finish_resp();

    // Request inputs wiggle during the scan and must be ignored.
    start_req(56'h8000_0000, 56'h8000_0FFF);
    req_base = '1; req_bounds = '0;
    @(negedge clk);
    req_base = 56'h123; req_bounds = 56'h7;
    @(negedge clk);
    wait_resp(3, lat);
    check("midchg_pmpaddr", 64'(resp_pmpaddr), 64'h2000_01FF);
    check("midchg_latency", 64'(lat), 64'd14);

    // Back-to-back: next request held valid during the response handshake.
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_base   = 56'h40;
    req_bounds = 56'h7F;
    @(negedge clk);
    resp_ready = 1'b0;
    check("b2b_idle_ready", {62'd0, req_ready, resp_valid}, 64'd2);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_taken", 64'(req_ready), 64'd0);
    wait_resp(1, lat);
    check("b2b_pmpaddr", 64'(resp_pmpaddr), 64'h17);
    check("b2b_size", 64'(resp_size_log2), 64'd6);
    check("b2b_latency", 64'(lat), 64'd8);
    finish_resp();

    // Reset during scan discards the request.
    run_directed("pre_rst", 56'h8000_0000, 56'h8000_0FFF, 64'h2000_01FF, 12, 1'b0, 14);
    start_req(56'h8000_0000, 56'h8000_0FFF);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready", 64'(req_ready), 64'd1);
    check("mid_rst_valid", 64'(resp_valid), 64'd0);
    check("mid_rst_outputs", {7'd0, resp_pmpaddr, resp_size_log2, resp_err}, 64'd0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | resp_valid;
    end
    check("no_stale_resp", 64'(seen), 64'd0);
    run_directed("post_rst", 56'h10, 56'h17, 64'h4, 3, 1'b0, 5);

    for (int k = 0; k < 16; k++) begin
      n = int'($urandom_range(56, 3));
      m = (64'd1 << n) - 64'd1;
      r = {$urandom, $urandom};
      run_model("rt", r[PADDR_W-1:0] & ~m[PADDR_W-1:0], r[PADDR_W-1:0] | m[PADDR_W-1:0]);
    end

    for (int k = 0; k < 24; k++) begin
      logic [PADDR_W-1:0] b, bd;
      r = {$urandom, $urandom};
      b = r[PADDR_W-1:0];
      case (k % 3)
        0: bd = b + PADDR_W'($urandom_range(64, 0));
        1: begin
          n  = int'($urandom_range(20, 3));
          m  = (64'd1 << n) - 64'd1;
          b  = b & ~m[PADDR_W-1:0];
          bd = (b | m[PADDR_W-1:0]) ^ (PADDR_W'(1) << $urandom_range(PADDR_W - 1, 0));
        end
        default: begin
          r  = {$urandom, $urandom};
          bd = r[PADDR_W-1:0];
        end
      endcase
      run_model("rnd", b, bd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
